// File: rtl/ansi_parser.sv
// VT100/ANSI escape filter: a byte FIFO feeds a GROUND/ESC/CSI parser that passes
// plain bytes through and turns the supported CSI sequences into one-shot command records.
module ansi_parser #(
   parameter int DEPTH = 8,
   parameter int COLS  = 80,
   parameter int ROWS  = 25
) (
   input  logic       clk25,
   input  logic       rst,
   input  logic       in_wr,
   input  logic [7:0] in_data,
   output logic       chr_valid,
   output logic [7:0] chr_data,
   output logic       cmd_valid,
   output logic [2:0] cmd_op,
   output logic [7:0] cmd_a,
   output logic [4:0] cmd_b,
   input  logic       dn_ready,
   output logic       ovf
);

   // state  | meaning
   // GROUND | plain bytes pass straight through as chr records
   // ESC    | 0x1B seen, waiting for '[' to open a control sequence
   // CSI    | collecting parameters until a final byte 0x40-0x7E
   typedef enum logic [1:0] {
      ST_GROUND,
      ST_ESC,
      ST_CSI
   } state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [2:0] OP_GOTO  = 3'd0;
   localparam logic [2:0] OP_UP    = 3'd1;
   localparam logic [2:0] OP_DOWN  = 3'd2;
   localparam logic [2:0] OP_RIGHT = 3'd3;
   localparam logic [2:0] OP_LEFT  = 3'd4;
   localparam logic [2:0] OP_CLRS  = 3'd5;
   localparam logic [2:0] OP_CLRE  = 3'd6;

   localparam logic [7:0] LP_COLS = 8'(COLS);
   localparam logic [7:0] LP_ROWS = 8'(ROWS);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   state_t        r_state;
   logic [7:0]    r_p0;
   logic [7:0]    r_p1;
   logic [1:0]    r_idx;

   logic          r_chr_valid;
   logic [7:0]    r_chr_data;
   logic          r_cmd_valid;
   logic [2:0]    r_cmd_op;
   logic [7:0]    r_cmd_a;
   logic [4:0]    r_cmd_b;

   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic          w_pop;
   logic          w_wr_ok;
   logic [7:0]    w_byte;

   logic [7:0]    w_psel;
   logic [11:0]   w_prod;
   logic [7:0]    w_acc;
   logic [7:0]    w_p0e;
   logic [7:0]    w_p1e;
   logic [7:0]    w_rowsel;
   logic [7:0]    w_colsel;
   logic [4:0]    w_row;
   logic [7:0]    w_col;

   logic          w_fin_emit;
   logic [2:0]    w_fin_op;
   logic [7:0]    w_fin_a;
   logic [4:0]    w_fin_b;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_busy  = r_chr_valid | r_cmd_valid;
   // A pending output may be replaced in the same cycle it is accepted, keeping one byte per cycle.
   assign w_pop   = !w_empty && (!w_busy || dn_ready);
   assign w_wr_ok = in_wr && (!w_full || w_pop);
   assign w_byte  = r_mem[r_rptr];

   assign w_psel = (r_idx == 2'd0) ? r_p0 : r_p1;
   assign w_prod = 12'(w_psel) * 12'd10 + {8'd0, w_byte[3:0]};
   assign w_acc  = (w_prod > 12'd255) ? 8'hFF : w_prod[7:0];

   assign w_p0e    = (r_p0 == 8'd0) ? 8'd1 : r_p0;
   assign w_p1e    = (r_p1 == 8'd0) ? 8'd1 : r_p1;
   assign w_rowsel = (w_p0e > LP_ROWS) ? LP_ROWS : w_p0e;
   assign w_colsel = (w_p1e > LP_COLS) ? LP_COLS : w_p1e;
   assign w_row    = 5'(w_rowsel - 8'd1);
   assign w_col    = w_colsel - 8'd1;

   always_comb begin
      w_fin_emit = 1'b0;
      w_fin_op   = OP_GOTO;
      w_fin_a    = 8'd0;
      w_fin_b    = 5'd0;
      case (w_byte)
         8'h48, 8'h66: begin
            w_fin_emit = 1'b1;
            w_fin_op   = OP_GOTO;
            w_fin_a    = w_col;
            w_fin_b    = w_row;
         end
         8'h41: begin w_fin_emit = 1'b1; w_fin_op = OP_UP;    w_fin_a = w_p0e; end
         8'h42: begin w_fin_emit = 1'b1; w_fin_op = OP_DOWN;  w_fin_a = w_p0e; end
         8'h43: begin w_fin_emit = 1'b1; w_fin_op = OP_RIGHT; w_fin_a = w_p0e; end
         8'h44: begin w_fin_emit = 1'b1; w_fin_op = OP_LEFT;  w_fin_a = w_p0e; end
         8'h4A: begin w_fin_emit = (r_p0 == 8'd2); w_fin_op = OP_CLRS; end
         8'h4B: begin w_fin_emit = (r_p0 == 8'd0); w_fin_op = OP_CLRE; end
         default: ;
      endcase
   end

   always_ff @(posedge clk25) begin
      if (w_wr_ok) r_mem[r_wptr] <= in_data;
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop)   r_rptr <= r_rptr + 1'b1;
         case ({w_wr_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
         if (in_wr && !w_wr_ok) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         r_state     <= ST_GROUND;
         r_p0        <= 8'd0;
         r_p1        <= 8'd0;
         r_idx       <= 2'd0;
         r_chr_valid <= 1'b0;
         r_chr_data  <= 8'd0;
         r_cmd_valid <= 1'b0;
         r_cmd_op    <= 3'd0;
         r_cmd_a     <= 8'd0;
         r_cmd_b     <= 5'd0;
      end else if (w_pop) begin
         r_chr_valid <= 1'b0;
         r_cmd_valid <= 1'b0;
         case (r_state)
            ST_GROUND: begin
               if (w_byte == 8'h1B) begin
                  r_state <= ST_ESC;
               end else begin
                  r_chr_valid <= 1'b1;
                  r_chr_data  <= w_byte;
               end
            end
            ST_ESC: begin
               if (w_byte == 8'h5B) begin
                  r_state <= ST_CSI;
                  r_p0    <= 8'd0;
                  r_p1    <= 8'd0;
                  r_idx   <= 2'd0;
               end else if (w_byte != 8'h1B) begin
                  r_state <= ST_GROUND;
               end
            end
            ST_CSI: begin
               if (w_byte == 8'h1B) begin
                  r_state <= ST_ESC;
               end else if (w_byte == 8'h18 || w_byte == 8'h1A) begin
                  r_state <= ST_GROUND;
               end else if (w_byte < 8'h20) begin
                  r_chr_valid <= 1'b1;
                  r_chr_data  <= w_byte;
               end else if (w_byte <= 8'h2F) begin
                  r_state <= ST_CSI;
               end else if (w_byte <= 8'h39) begin
                  if (r_idx == 2'd0)      r_p0 <= w_acc;
                  else if (r_idx == 2'd1) r_p1 <= w_acc;
               end else if (w_byte == 8'h3B) begin
                  if (r_idx != 2'd2) r_idx <= r_idx + 2'd1;
               end else if (w_byte >= 8'h40 && w_byte <= 8'h7E) begin
                  r_state <= ST_GROUND;
                  if (w_fin_emit) begin
                     r_cmd_valid <= 1'b1;
                     r_cmd_op    <= w_fin_op;
                     r_cmd_a     <= w_fin_a;
                     r_cmd_b     <= w_fin_b;
                  end
               end
            end
            default: r_state <= ST_GROUND;
         endcase
      end else if (dn_ready) begin
         r_chr_valid <= 1'b0;
         r_cmd_valid <= 1'b0;
      end
   end

   assign chr_valid = r_chr_valid;
   assign chr_data  = r_chr_data;
   assign cmd_valid = r_cmd_valid;
   assign cmd_op    = r_cmd_op;
   assign cmd_a     = r_cmd_a;
   assign cmd_b     = r_cmd_b;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_ansi_parser.sv
// Directed bench for ansi_parser: records every accepted chr/cmd transfer and compares
// against hand-computed expectations; also watches hold stability and valid exclusivity.
module tb_ansi_parser;

   logic       clk25 = 1'b0;
   logic       rst;
   logic       in_wr;
   logic [7:0] in_data;
   logic       chr_valid;
   logic [7:0] chr_data;
   logic       cmd_valid;
   logic [2:0] cmd_op;
   logic [7:0] cmd_a;
   logic [4:0] cmd_b;
   logic       dn_ready;
   logic       ovf;

   int n_err = 0;
   int n_chk = 0;
   int both_high = 0;
   int unstable = 0;

   logic [7:0]  q_chr[$];
   logic [15:0] q_cmd[$];
   logic        hold_prev = 1'b0;
   logic [25:0] snap_prev = '0;
   logic [25:0] w_snap;

   ansi_parser #(.DEPTH(8), .COLS(80), .ROWS(25)) dut (
      .clk25     (clk25),
      .rst       (rst),
      .in_wr     (in_wr),
      .in_data   (in_data),
      .chr_valid (chr_valid),
      .chr_data  (chr_data),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .dn_ready  (dn_ready),
      .ovf       (ovf)
   );

   always #20 clk25 = ~clk25;

   assign w_snap = {chr_valid, cmd_valid, chr_data, cmd_op, cmd_a, cmd_b};

   always @(negedge clk25) begin
      if (rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (chr_valid && cmd_valid) both_high <= both_high + 1;
         if (hold_prev && (w_snap !== snap_prev)) unstable <= unstable + 1;
         if (chr_valid && dn_ready) q_chr.push_back(chr_data);
         if (cmd_valid && dn_ready) q_cmd.push_back({cmd_op, cmd_a, cmd_b});
         hold_prev <= (chr_valid || cmd_valid) && !dn_ready;
         snap_prev <= w_snap;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_wr   = 1'b1;
      in_data = b;
      @(posedge clk25); #1;
      in_wr   = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic send_csi(input string s);
      send_byte(8'h1B);
      send_byte(8'h5B);
      send_str(s);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk25);
      #1;
   endtask

   task automatic clear_q();
      q_chr.delete();
      q_cmd.delete();
   endtask

   task automatic expect_cmd(input string tag, input logic [2:0] op,
                             input logic [7:0] a, input logic [4:0] b);
      logic [15:0] rec;
      settle(12);
      rec = {op, a, b};
      chk({tag, "_ncmd"}, q_cmd.size(), 1);
      chk({tag, "_nchr"}, q_chr.size(), 0);
      if (q_cmd.size() > 0) chk({tag, "_rec"}, int'(q_cmd[0]), int'(rec));
      clear_q();
   endtask

   task automatic expect_chr(input string tag, input logic [7:0] c);
      settle(12);
      chk({tag, "_ncmd"}, q_cmd.size(), 0);
      chk({tag, "_nchr"}, q_chr.size(), 1);
      if (q_chr.size() > 0) chk({tag, "_chr"}, int'(q_chr[0]), int'(c));
      clear_q();
   endtask

   task automatic expect_none(input string tag);
      settle(12);
      chk({tag, "_ncmd"}, q_cmd.size(), 0);
      chk({tag, "_nchr"}, q_chr.size(), 0);
      clear_q();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_wr    = 1'b0;
      in_data  = 8'h00;
      dn_ready = 1'b1;
      settle(3);
      @(negedge clk25);
      chk("rst_outs", int'(w_snap), 0);
      chk("rst_ovf", int'(ovf), 0);
      @(posedge clk25); #1;
      rst = 1'b0;

      // Two-cycle latency from write strobe to chr_valid
      @(posedge clk25); #1;
      send_byte(8'h41);
      @(negedge clk25);
      chk("lat_n1", int'(chr_valid), 0);
      @(negedge clk25);
      chk("lat_n2_valid", int'(chr_valid), 1);
      chk("lat_n2_data", int'(chr_data), 8'h41);
      @(negedge clk25);
      chk("lat_pulse_end", int'(chr_valid), 0);
      @(posedge clk25); #1;
      expect_chr("pass_A", 8'h41);

      send_csi("12;40H");
      expect_cmd("goto_12_40", 3'd0, 8'd39, 5'd11);
      send_csi("H");
      expect_cmd("goto_home", 3'd0, 8'd0, 5'd0);
      send_csi("99;200H");
      expect_cmd("goto_clamp", 3'd0, 8'd79, 5'd24);
      send_csi("5A");
      expect_cmd("up5", 3'd1, 8'd5, 5'd0);
      send_csi("2J");
      expect_cmd("clr_scr", 3'd5, 8'd0, 5'd0);
      send_csi("300C");
      expect_cmd("right_sat", 3'd3, 8'd255, 5'd0);
      send_csi("D");
      expect_cmd("left_def", 3'd4, 8'd1, 5'd0);
      send_csi("K");
      expect_cmd("clr_eol", 3'd6, 8'd0, 5'd0);
      send_csi("1K");
      expect_none("eol_1_drop");
      send_csi("1J");
      expect_none("clr_1_drop");
      send_csi("1;31mx");
      expect_chr("sgr_then_x", 8'h78);
      send_csi("3");
      send_byte(8'h18);
      send_byte(8'h79);
      expect_chr("can_abort", 8'h79);
      send_byte(8'h1B);
      send_byte(8'h1B);
      send_csi("B");
      expect_cmd("esc_esc_down", 3'd2, 8'd1, 5'd0);
      send_byte(8'h1B);
      send_str("Zq");
      expect_chr("esc_junk", 8'h71);
      send_csi("7;8;9H");
      expect_cmd("goto_3args", 3'd0, 8'd7, 5'd6);

      // Control byte inside CSI is passed through, sequence continues
      send_csi("");
      send_byte(8'h0D);
      send_str("2J");
      settle(12);
      chk("ctl_in_csi_nchr", q_chr.size(), 1);
      chk("ctl_in_csi_ncmd", q_cmd.size(), 1);
      if (q_chr.size() > 0) chk("ctl_in_csi_chr", int'(q_chr[0]), 8'h0D);
      if (q_cmd.size() > 0) chk("ctl_in_csi_cmd", int'(q_cmd[0]), int'({3'd5, 8'd0, 5'd0}));
      clear_q();

      // Stall downstream and overfill the FIFO
      dn_ready = 1'b0;
      for (int i = 0; i < 12; i++) send_byte(8'h61 + 8'(i));
      settle(2);
      @(negedge clk25);
      chk("ovf_set", int'(ovf), 1);
      chk("stall_valid", int'(chr_valid), 1);
      chk("stall_data", int'(chr_data), 8'h61);
      @(posedge clk25); #1;
      dn_ready = 1'b1;
      settle(20);
      chk("ovf_count", q_chr.size(), 9);
      for (int i = 0; i < 9; i++) begin
         if (i < q_chr.size()) chk($sformatf("ovf_ord%0d", i), int'(q_chr[i]), 8'h61 + i);
      end
      chk("ovf_ncmd", q_cmd.size(), 0);
      chk("ovf_sticky", int'(ovf), 1);
      clear_q();

      // Reset mid-sequence abandons it and clears ovf
      send_csi("1");
      rst = 1'b1;
      @(posedge clk25); #1;
      rst = 1'b0;
      send_str("2J");
      settle(12);
      chk("rst_mid_nchr", q_chr.size(), 2);
      chk("rst_mid_ncmd", q_cmd.size(), 0);
      if (q_chr.size() > 1) begin
         chk("rst_mid_c0", int'(q_chr[0]), 8'h32);
         chk("rst_mid_c1", int'(q_chr[1]), 8'h4A);
      end
      chk("rst_mid_ovf", int'(ovf), 0);
      clear_q();

      chk("both_valid", both_high, 0);
      chk("hold_stable", unstable, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ansi_parser.md
Name: ansi_parser

Overview:
- Sits between the serial receiver and the terminal RX state machine.
- Buffers received bytes in a small FIFO and passes printable and control bytes through unchanged.
- Decodes the VT100/ANSI CSI subset (cursor position, relative moves, erase) into single-cycle command records for the downstream screen logic.
- Consumes SGR and unsupported sequences silently, so escape garbage never reaches video RAM.

Parameters:
- DEPTH, 8: input FIFO entries; power of two, minimum 2.
- COLS, 80: screen columns; clamp limit for column arguments.
- ROWS, 25: screen rows; clamp limit for row arguments.

Ports:
- clk25 input 1: system clock.
- rst input 1: synchronous, active-high reset.
- in_wr input 1: one-cycle strobe; in_data is valid.
- in_data input 8: received byte.
- chr_valid output 1: pass-through byte available.
- chr_data output 8: pass-through byte.
- cmd_valid output 1: command record available.
- cmd_op output 3: 0 GOTO, 1 UP, 2 DOWN, 3 RIGHT, 4 LEFT, 5 CLR_SCREEN, 6 CLR_EOL.
- cmd_a output 8: GOTO column (0-based), or move count.
- cmd_b output 5: GOTO row (0-based); 0 for all other ops.
- dn_ready input 1: downstream accepts chr or cmd this cycle.
- ovf output 1: sticky FIFO overflow flag.

Behaviour:
- Reset:
  - FIFO empty; parser in GROUND; params cleared.
  - chr_valid=0, cmd_valid=0, chr_data=0, cmd_op=0, cmd_a=0, cmd_b=0, ovf=0.
  - A reset mid-sequence abandons the sequence; no partial output.
- FIFO:
  - in_wr while full: byte dropped, ovf<=1. ovf is cleared only by rst.
  - A simultaneous write and pop on a full FIFO is accepted (count unchanged).
  - Pointers wrap modulo DEPTH.
- Output register:
  - chr_valid and cmd_valid are never high together.
  - Once raised, valid and payload are held stable until a cycle with dn_ready=1, then valid drops next cycle.
  - The parser pops the FIFO only when no output is pending, or when the pending output is being accepted this cycle.
  - Throughput: one byte per cycle.
- Latency: in_wr at cycle N with FIFO empty and output idle gives chr_valid at N+2.
- States:
  - GROUND:
    - 0x1B -> ESC.
    - Any other byte -> chr_valid with chr_data=byte.
  - ESC:
    - '[' -> CSI; clear p0, p1 and the param index.
    - 0x1B stays in ESC.
    - Anything else is discarded -> GROUND.
  - CSI:
    - '0'-'9': p[idx] = p[idx]*10 + digit, saturating at 255. Only while idx<2; digits for idx>=2 are ignored.
    - ';': idx++ (saturates at 2).
    - 0x20-0x2F (intermediates): ignored.
    - 0x1B -> ESC.
    - 0x18 / 0x1A: abort -> GROUND, nothing emitted.
    - Other bytes <0x20: emitted as chr; remain in CSI.
    - 0x40-0x7E (final byte): decode, then -> GROUND.
- Final-byte decode (a parameter of 0 or absent counts as 1 unless noted):
  - 'H' / 'f': GOTO with cmd_b=min(p0,ROWS)-1, cmd_a=min(p1,COLS)-1.
  - 'A', 'B', 'C', 'D': UP, DOWN, RIGHT, LEFT with cmd_a=p0 (1..255).
  - 'J': p0==2 gives CLR_SCREEN; any other value is discarded.
  - 'K': p0==0 gives CLR_EOL; any other value is discarded.
  - 'm' and all other finals: consumed, nothing emitted.
- Bytes 0x7F-0xFF in CSI: discarded; state stays CSI.

Test Plan:
- Write 0x41, dn_ready=1 -> chr_valid pulse 2 cycles later with chr_data=0x41; no cmd_valid.
- Write ESC '[' '1' '2' ';' '4' '0' 'H' -> exactly one cmd_valid: op=0, a=39, b=11. ESC '[' 'H' -> op=0, a=0, b=0.
- Write ESC '[' '9' '9' ';' '2' '0' '0' 'H' -> op=0, a=79, b=24. ESC '[' '5' 'A' -> op=1, a=5. ESC '[' '2' 'J' -> op=5.
- Write ESC '[' '1' ';' '3' '1' 'm' 'x' -> no cmd; single chr 0x78. ESC '[' '3' 0x18 'y' -> only chr 0x79.
- Hold dn_ready=0 and write 12 bytes -> ovf=1. Release dn_ready -> exactly DEPTH+1 (9) bytes delivered in order, payload stable while stalled.
- Write ESC '[' '1', then pulse rst, then '2' 'J' -> chr 0x32 then chr 0x4A; no cmd; ovf=0.
